// File: rtl/mem_bridge_if.sv
// Bundles the CPU-side level-held memory handshake and the physical memory port
// of mem_bridge. The bridge uses the slave modport; the environment uses master.
interface mem_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  // CPU side: mem_read/mem_write are held until a one-cycle mem_resp pulse.
  // Memory side: pmem_req and the pmem_* payload stay stable until the cycle
  // pmem_ready is high; pmem_ack (with pmem_rdata) completes the access.
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_byte_enable;
  logic [15:0]           mem_wdata;
  logic                  mem_resp;
  logic [15:0]           mem_rdata;

  logic                  pmem_req;
  logic                  pmem_we;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [15:0]           pmem_wdata;
  logic [1:0]            pmem_wmask;
  logic                  pmem_ready;
  logic                  pmem_ack;
  logic [15:0]           pmem_rdata;

  logic                  err;
  logic                  err_clear;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_wmask,
    input  pmem_ready, pmem_ack, pmem_rdata,
    output err,
    input  err_clear
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_wmask,
    output pmem_ready, pmem_ack, pmem_rdata,
    input  err,
    output err_clear
  );
endinterface

// File: rtl/mem_bridge.sv
// Converts the LC-3b level-held memory handshake into a req/ready/ack physical
// memory access, with a sticky error flag and a stall timeout.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  mem_bridge_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            wmask_q, wmask_d;
  logic                  we_q, we_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [CW-1:0]         cnt_inc;
  logic                  tmo_hit;
  logic                  err_set;

  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    err_set = 1'b0;

    if (state_q == ISSUE || state_q == WAIT) cnt_d = cnt_inc;

    case (state_q)
      IDLE: begin
        if (bus.mem_write) begin
          err_set = bus.mem_read;
          if (bus.mem_byte_enable != 2'b00) begin
            addr_d  = bus.mem_address & ~ADDR_WIDTH'(1);
            wdata_d = bus.mem_wdata;
            wmask_d = bus.mem_byte_enable;
            we_d    = 1'b1;
            state_d = ISSUE;
          end else begin
            // Nothing to write: complete without touching memory.
            state_d = RESP;
          end
        end else if (bus.mem_read) begin
          addr_d  = bus.mem_address & ~ADDR_WIDTH'(1);
          wdata_d = bus.mem_wdata;
          wmask_d = 2'b11;
          we_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.pmem_ready && bus.pmem_ack) begin
          if (!we_q) rdata_d = bus.pmem_rdata;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = 16'h0000;
          err_set = 1'b1;
          state_d = RESP;
        end else if (bus.pmem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.pmem_ack) begin
          if (!we_q) rdata_d = bus.pmem_rdata;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = 16'h0000;
          err_set = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // The CPU still holds its request here; it is sampled again only in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_set)            err_d = 1'b1;
    else if (bus.err_clear) err_d = 1'b0;
    else                    err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 2'b11;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_resp   = (state_q == RESP);
  assign bus.mem_rdata  = rdata_q;
  assign bus.pmem_req   = (state_q == ISSUE);
  assign bus.pmem_we    = we_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.pmem_wmask = wmask_q;
  assign bus.err        = err_q;
  assign dbg_state      = state_q;

endmodule
